// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared types and constants for the output mismatch monitor
// Contents:
//   mon_state_t  monitor FSM state encoding (IDLE=0, RUN=1, FAIL=2)
//   CONSEC_W     width of the internal consecutive-mismatch counter
//   sat_inc8     saturating increment at CONSEC_W bits
package mon_pkg;

   typedef enum logic [1:0] {
      MON_IDLE = 2'd0,
      MON_RUN  = 2'd1,
      MON_FAIL = 2'd2
   } mon_state_t;

   localparam int CONSEC_W = 8;

   // Value the consec counter will hold after one more mismatch.
   function automatic logic [CONSEC_W-1:0] sat_inc8(input logic [CONSEC_W-1:0] v);
      return (v == {CONSEC_W{1'b1}}) ? v : v + CONSEC_W'(1);
   endfunction

endpackage

// File: rtl/output_mismatch_monitor_sat_counter.sv
// rtl/output_mismatch_monitor_sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear to zero
//   inc  in   increment by one; ignored once q is all-ones
//   q    out  count value
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/output_mismatch_monitor.sv
// rtl/output_mismatch_monitor.sv - run-time o1/o2 equivalence monitor with sticky fail
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   en              in   run enable (level)
//   clr             in   synchronous clear of state and all counters
//   o1_i, o2_i      in   the two upstream outputs being compared
//   busy            out  state is RUN
//   fail            out  state is FAIL (sticky until clr/rst)
//   mism_cnt        out  mismatching samples since last start (saturating)
//   cycle_cnt       out  samples taken since last start (saturating)
//   first_fail_cyc  out  cycle_cnt value after the sample that caused FAIL
//   state_o         out  encoded state
module output_mismatch_monitor
   import mon_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int FAIL_LIMIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             o1_i,
   input  logic             o2_i,
   output logic             busy,
   output logic             fail,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] first_fail_cyc,
   output logic [1:0]       state_o
);

   mon_state_t          state;
   mon_state_t          state_nxt;
   logic [CONSEC_W-1:0] consec;
   logic [CONSEC_W-1:0] consec_next;
   logic [CNT_W-1:0]    cycle_next;
   logic                mismatch;
   logic                start;
   logic                sample;
   logic                fail_hit;
   logic                cnt_clr;
   logic                consec_clr;

   assign mismatch = o1_i ^ o2_i;

   // clr overrides en, so neither a start nor a sample happens on a clr edge.
   assign start  = (state == MON_IDLE) && en && !clr;
   assign sample = (state == MON_RUN)  && en && !clr;

   // Post-increment values, used for the FAIL decision and the capture.
   assign consec_next = sat_inc8(consec);
   assign cycle_next  = (cycle_cnt == {CNT_W{1'b1}}) ? cycle_cnt : cycle_cnt + CNT_W'(1);

   // A failing sample only counts when en is high; en=0 on that edge wins.
   assign fail_hit = sample && mismatch && (consec_next == CONSEC_W'(FAIL_LIMIT));

   assign cnt_clr    = clr || start;
   assign consec_clr = clr || start || (sample && !mismatch);

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (sample),
      .q   (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mism_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (sample && mismatch),
      .q   (mism_cnt)
   );

   sat_counter #(.W(CONSEC_W)) u_consec (
      .clk (clk),
      .rst (rst),
      .clr (consec_clr),
      .inc (sample && mismatch),
      .q   (consec)
   );

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         first_fail_cyc <= '0;
      end else if (fail_hit) begin
         first_fail_cyc <= cycle_next;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MON_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = MON_IDLE;
      end else begin
         case (state)
            MON_IDLE: if (en) state_nxt = MON_RUN;
            MON_RUN: begin
               if (!en) begin
                  state_nxt = MON_IDLE;
               end else if (fail_hit) begin
                  state_nxt = MON_FAIL;
               end
            end
            MON_FAIL: state_nxt = MON_FAIL;
            default:  state_nxt = MON_IDLE;
         endcase
      end
   end

   // FSM: outputs decoded from the state register
   always_comb begin
      busy    = (state == MON_RUN);
      fail    = (state == MON_FAIL);
      state_o = state;
   end

endmodule

// File: tb/tb_output_mismatch_monitor.sv
// tb/tb_output_mismatch_monitor.sv - directed self-checking bench for output_mismatch_monitor
module tb_output_mismatch_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic en  = 1'b0;
   logic o1  = 1'b0;
   logic o2  = 1'b0;

   logic        a_busy, a_fail;
   logic [15:0] a_mism, a_cyc, a_ffc;
   logic [1:0]  a_st;
   logic        b_busy, b_fail;
   logic [3:0]  b_mism, b_cyc, b_ffc;
   logic [1:0]  b_st;
   logic        c_busy, c_fail;
   logic [15:0] c_mism, c_cyc, c_ffc;
   logic [1:0]  c_st;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   output_mismatch_monitor #(.CNT_W(16), .FAIL_LIMIT(2)) u_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .o1_i(o1), .o2_i(o2),
      .busy(a_busy), .fail(a_fail), .mism_cnt(a_mism), .cycle_cnt(a_cyc),
      .first_fail_cyc(a_ffc), .state_o(a_st)
   );

   output_mismatch_monitor #(.CNT_W(4), .FAIL_LIMIT(255)) u_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .o1_i(o1), .o2_i(o2),
      .busy(b_busy), .fail(b_fail), .mism_cnt(b_mism), .cycle_cnt(b_cyc),
      .first_fail_cyc(b_ffc), .state_o(b_st)
   );

   output_mismatch_monitor u_c (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .o1_i(o1), .o2_i(o2),
      .busy(c_busy), .fail(c_fail), .mism_cnt(c_mism), .cycle_cnt(c_cyc),
      .first_fail_cyc(c_ffc), .state_o(c_st)
   );

   typedef struct {
      logic        rst, clr, en, o1, o2;
      logic [1:0]  st;
      logic        fail, busy;
      logic [15:0] cyc, mism, ffc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic c, input logic e, input logic a,
                      input logic b, input logic [1:0] st, input logic f, input logic bz,
                      input int cyc, input int mism, input int ffc);
      vec_t v;
      v.rst = r; v.clr = c; v.en = e; v.o1 = a; v.o2 = b;
      v.st = st; v.fail = f; v.busy = bz;
      v.cyc = 16'(cyc); v.mism = 16'(mism); v.ffc = 16'(ffc);
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Table for u_a (CNT_W=16, FAIL_LIMIT=2). Columns:
      // rst clr en o1 o2 | state fail busy cycle_cnt mism_cnt first_fail_cyc
      repeat (3) add(1,0,1,0,0, 0,0,0, 0,0,0);
      add(0,0,0,0,0, 0,0,0, 0,0,0);
      add(0,0,1,0,0, 1,0,1, 0,0,0);              // start, no sample
      for (int k = 1; k <= 10; k++)
         add(0,0,1,k[0],k[0], 1,0,1, k,0,0);     // 10 matching samples
      add(0,0,0,1,0, 0,0,0, 10,0,0);             // en=0: sample discarded, counters hold
      add(0,0,1,0,0, 1,0,1, 0,0,0);              // restart zeroes counters
      add(0,0,1,0,0, 1,0,1, 1,0,0);
      add(0,0,1,1,1, 1,0,1, 2,0,0);
      add(0,0,1,0,0, 1,0,1, 3,0,0);
      add(0,0,1,1,0, 1,0,1, 4,1,0);              // lone mismatch on sample 4
      add(0,0,1,0,0, 1,0,1, 5,1,0);
      add(0,0,1,1,1, 1,0,1, 6,1,0);
      add(0,0,1,0,1, 1,0,1, 7,2,0);
      add(0,0,1,1,0, 2,1,0, 8,3,8);              // second in a row -> FAIL
      for (int k = 0; k < 5; k++)
         add(0,0,k[0],1,0, 2,1,0, 8,3,8);        // frozen in FAIL
      add(0,1,1,0,0, 0,0,0, 0,0,0);              // clr+en in FAIL -> IDLE
      add(0,0,1,0,0, 1,0,1, 0,0,0);
      add(0,0,1,1,0, 1,0,1, 1,1,0);
      add(1,0,1,0,1, 0,0,0, 0,0,0);              // rst on the failing sample
      add(0,0,1,0,0, 1,0,1, 0,0,0);
      add(0,0,1,1,0, 1,0,1, 1,1,0);
      add(0,0,0,1,0, 0,0,0, 1,1,0);              // en=0 beats the failing mismatch
      add(0,0,1,0,0, 1,0,1, 0,0,0);
      add(0,0,1,1,0, 1,0,1, 1,1,0);
      add(0,0,1,1,1, 1,0,1, 2,1,0);              // match resets consec
      add(0,0,1,0,1, 1,0,1, 3,2,0);
      add(0,1,1,0,1, 0,0,0, 0,0,0);              // clr on the failing sample
      add(0,0,1,0,0, 1,0,1, 0,0,0);
      add(0,0,1,1,0, 1,0,1, 1,1,0);
      add(0,0,1,1,0, 2,1,0, 2,2,2);
      add(0,0,0,0,0, 2,1,0, 2,2,2);              // en=0 has no effect in FAIL
      add(1,0,0,0,0, 0,0,0, 0,0,0);              // rst leaves FAIL

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; clr = vecs[i].clr; en = vecs[i].en;
         o1 = vecs[i].o1;   o2 = vecs[i].o2;
         tick();
         check("state",     i, 32'(a_st),   32'(vecs[i].st));
         check("fail",      i, 32'(a_fail), 32'(vecs[i].fail));
         check("busy",      i, 32'(a_busy), 32'(vecs[i].busy));
         check("cycle_cnt", i, 32'(a_cyc),  32'(vecs[i].cyc));
         check("mism_cnt",  i, 32'(a_mism), 32'(vecs[i].mism));
         check("first_fail",i, 32'(a_ffc),  32'(vecs[i].ffc));
      end

      // Saturation (u_b: CNT_W=4, FAIL_LIMIT=255) and immediate fail (u_c: defaults).
      rst = 1'b1; clr = 1'b0; en = 1'b0; o1 = 1'b0; o2 = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1;
      tick();
      check("b_start_busy", 0, 32'(b_busy), 32'd1);
      o1 = 1'b1;
      repeat (14) tick();
      check("b_cyc14",  0, 32'(b_cyc),  32'd14);
      check("b_mism14", 0, 32'(b_mism), 32'd14);
      repeat (6) tick();
      check("b_cyc_sat",  0, 32'(b_cyc),  32'd15);
      check("b_mism_sat", 0, 32'(b_mism), 32'd15);
      check("b_fail",     0, 32'(b_fail), 32'd0);
      check("b_state",    0, 32'(b_st),   32'd1);
      repeat (3) tick();
      check("b_cyc_hold",  0, 32'(b_cyc),  32'd15);
      check("b_mism_hold", 0, 32'(b_mism), 32'd15);
      check("b_ffc",       0, 32'(b_ffc),  32'd0);
      check("c_state", 0, 32'(c_st),   32'd2);
      check("c_fail",  0, 32'(c_fail), 32'd1);
      check("c_ffc",   0, 32'(c_ffc),  32'd1);
      check("c_cyc",   0, 32'(c_cyc),  32'd1);
      check("c_mism",  0, 32'(c_mism), 32'd1);
      check("a_ffc",   0, 32'(a_ffc),  32'd2);
      check("a_mism",  0, 32'(a_mism), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
